// File: rtl/sha1_pkg.sv
// Shared SHA-1 types and constants for the padder and future sha1 refactors.
package sha1_pkg;

    localparam int unsigned SHA1_BLOCK_BITS = 512;
    localparam int unsigned SHA1_LEN_BITS   = 64;
    localparam logic [7:0]  SHA1_PAD_BYTE   = 8'h80;
    localparam int unsigned SHA1_LEN_SLOT   = 56;

    typedef enum logic [2:0] {
        FILL,
        FULL,
        PAD,
        SPILL,
        LAST
    } sha1_pad_state_t;

endpackage

// File: rtl/sha1_padder_if.sv
// Byte-in / block-out handshake bundle for sha1_padder.
interface sha1_padder_if;
    import sha1_pkg::*;

    logic                       in_valid;
    logic [7:0]                 in_data;
    logic                       in_last;
    logic                       in_ready;
    logic                       block_valid;
    logic [SHA1_BLOCK_BITS-1:0] block_data;
    logic                       block_last;
    logic                       block_ready;
    logic                       busy;

    // master: the padder, producing blocks from the byte stream
    modport master (
        input  in_valid, in_data, in_last, block_ready,
        output in_ready, block_valid, block_data, block_last, busy
    );

    // slave: the environment feeding bytes and consuming blocks
    modport slave (
        output in_valid, in_data, in_last, block_ready,
        input  in_ready, block_valid, block_data, block_last, busy
    );

endinterface

// File: rtl/sha1_padder.sv
// Packs a byte stream into 512-bit SHA-1 blocks with 0x80 marker, zero fill
// and a big-endian 64-bit bit-length trailer.
module sha1_padder
    import sha1_pkg::*;
#(
    parameter int unsigned LEN_BITS = SHA1_LEN_BITS
) (
    input  logic          clk,
    input  logic          reset_n,
    sha1_padder_if.master bus
);

    localparam int unsigned CNT_BITS = LEN_BITS - 3;

    sha1_pad_state_t            state_q, state_d;
    logic [SHA1_BLOCK_BITS-1:0] buf_q, buf_d;
    logic [5:0]                 pos_q, pos_d;
    logic [CNT_BITS-1:0]        cnt_q, cnt_d;
    logic                       ended_q, ended_d;

    logic                       accept;
    logic                       handshake;
    logic [LEN_BITS-1:0]        bit_len;
    logic [8:0]                 wr_hi;

    assign accept    = bus.in_valid && (state_q == FILL);
    assign handshake = bus.block_ready &&
                       ((state_q == FULL) || (state_q == SPILL) || (state_q == LAST));
    assign bit_len   = {cnt_q, 3'b000};
    assign wr_hi     = 9'd511 - {pos_q, 3'b000};

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= FILL;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            FILL: begin
                // pos wraps to 0 on the 64th byte; FULL itself marks the full buffer
                if (accept) begin
                    if (pos_q == 6'd63) begin
                        state_d = FULL;
                    end else if (bus.in_last) begin
                        state_d = PAD;
                    end
                end
            end
            FULL: begin
                if (handshake) begin
                    state_d = ended_q ? PAD : FILL;
                end
            end
            PAD: begin
                state_d = (pos_q < 6'(SHA1_LEN_SLOT)) ? LAST : SPILL;
            end
            SPILL: begin
                if (handshake) begin
                    state_d = LAST;
                end
            end
            LAST: begin
                if (handshake) begin
                    state_d = FILL;
                end
            end
            default: state_d = FILL;
        endcase
    end

    always_comb begin
        bus.in_ready    = (state_q == FILL);
        bus.block_valid = (state_q == FULL) || (state_q == SPILL) || (state_q == LAST);
        bus.block_last  = (state_q == LAST);
        bus.block_data  = buf_q;
        bus.busy        = !((state_q == FILL) && (pos_q == '0) && (cnt_q == '0));
    end

    always_comb begin
        buf_d   = buf_q;
        pos_d   = pos_q;
        cnt_d   = cnt_q;
        ended_d = ended_q;
        case (state_q)
            FILL: begin
                if (accept) begin
                    buf_d[wr_hi -: 8] = bus.in_data;
                    pos_d             = pos_q + 6'd1;
                    cnt_d             = cnt_q + CNT_BITS'(1);
                    if (pos_q == 6'd63) begin
                        ended_d = bus.in_last;
                    end
                end
            end
            FULL: begin
                if (handshake) begin
                    buf_d = '0;
                    pos_d = '0;
                end
            end
            PAD: begin
                buf_d[wr_hi -: 8] = SHA1_PAD_BYTE;
                if (pos_q < 6'(SHA1_LEN_SLOT)) begin
                    buf_d[LEN_BITS-1:0] = bit_len;
                end
            end
            SPILL: begin
                if (handshake) begin
                    buf_d               = '0;
                    buf_d[LEN_BITS-1:0] = bit_len;
                end
            end
            LAST: begin
                if (handshake) begin
                    buf_d   = '0;
                    pos_d   = '0;
                    cnt_d   = '0;
                    ended_d = 1'b0;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            buf_q   <= '0;
            pos_q   <= '0;
            cnt_q   <= '0;
            ended_q <= 1'b0;
        end else begin
            buf_q   <= buf_d;
            pos_q   <= pos_d;
            cnt_q   <= cnt_d;
            ended_q <= ended_d;
        end
    end

endmodule

// File: tb/tb_sha1_padder.sv
// Self-checking bench for sha1_padder: table-driven lengths, hand-written
// stall/reset sequences, and randomized messages against a padding model.
module tb_sha1_padder;

    logic clk = 1'b0;
    logic reset_n;
    always #5 clk = ~clk;

    sha1_padder_if bus ();

    sha1_padder #(.LEN_BITS(64)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus.master)
    );

    typedef struct {
        logic [511:0] data;
        logic         last;
        int unsigned  cyc;
    } blk_t;

    typedef struct {
        int unsigned len;
        int unsigned pat;
        int unsigned exp_blocks;
        int unsigned exp_lat;
        int unsigned exp_gap;
    } vec_t;

    blk_t         got_q[$];
    blk_t         exp_q[$];
    byte unsigned msg[$];
    int unsigned  cyc = 0;
    int unsigned  last_acc_cyc = 0;
    int           checks = 0;
    int           errors = 0;
    int unsigned  rdy_mode = 0;
    logic [511:0] abc_ref;
    vec_t         vecs[11];

    always @(posedge clk) begin
        if (reset_n === 1'b1) begin
            if (bus.in_valid && bus.in_ready && bus.in_last) last_acc_cyc = cyc;
            if (bus.block_valid && bus.block_ready)
                got_q.push_back('{bus.block_data, bus.block_last, cyc});
        end
        cyc++;
    end

    always @(negedge clk) begin
        case (rdy_mode)
            0:       bus.block_ready = 1'b1;
            1:       bus.block_ready = ($urandom_range(0, 3) != 0);
            default: bus.block_ready = 1'b0;
        endcase
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [511:0] got, input logic [511:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, got, want);
        end
    endtask

    task automatic make_msg(input int unsigned len, input int unsigned pat);
        msg.delete();
        for (int unsigned i = 0; i < len; i++)
            msg.push_back((pat != 0) ? 8'($urandom) : 8'h00);
    endtask

    // Reference: append 0x80, zero-pad to 56 mod 64, append 64-bit bit length.
    task automatic build_expected();
        byte unsigned   p[$];
        longint unsigned bits;
        int unsigned     nblk;
        exp_q.delete();
        p = msg;
        p.push_back(8'h80);
        while ((p.size() % 64) != 56) p.push_back(8'h00);
        bits = longint'(msg.size()) * 8;
        for (int i = 7; i >= 0; i--) p.push_back(8'(bits >> (8 * i)));
        nblk = p.size() / 64;
        for (int unsigned b = 0; b < nblk; b++) begin
            blk_t e;
            e.data = '0;
            for (int unsigned k = 0; k < 64; k++) e.data[511 - 8 * k -: 8] = p[64 * b + k];
            e.last = (b == nblk - 1);
            e.cyc  = 0;
            exp_q.push_back(e);
        end
    endtask

    task automatic send_msg(input bit with_last);
        for (int unsigned i = 0; i < msg.size(); i++) begin
            int unsigned w = 0;
            bus.in_valid = 1'b1;
            bus.in_data  = msg[i];
            bus.in_last  = with_last && (i == msg.size() - 1);
            while (!bus.in_ready && w < 2000) begin
                step();
                w++;
            end
            if (!bus.in_ready) begin
                chk("in_ready_timeout", 512'(bus.in_ready), 512'(1));
                break;
            end
            step();
        end
        bus.in_valid = 1'b0;
        bus.in_last  = 1'b0;
    endtask

    task automatic wait_blocks(input int unsigned n);
        int unsigned w = 0;
        while (got_q.size() < n && w < 5000) begin
            step();
            w++;
        end
        chk("block_count", 512'(got_q.size()), 512'(n));
    endtask

    task automatic compare_blocks(input string tag);
        wait_blocks(exp_q.size());
        for (int unsigned i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
            chk($sformatf("%s_data%0d", tag, i), got_q[i].data, exp_q[i].data);
            chk($sformatf("%s_last%0d", tag, i), 512'(got_q[i].last), 512'(exp_q[i].last));
        end
    endtask

    task automatic run_abc(input string tag);
        msg.delete();
        msg.push_back(8'h61);
        msg.push_back(8'h62);
        msg.push_back(8'h63);
        build_expected();
        got_q.delete();
        send_msg(1'b1);
        compare_blocks(tag);
    endtask

    initial begin
        int unsigned first;
        int unsigned w;
        logic [511:0] held;

        vecs = '{
            '{1,   1, 1, 2, 0},
            '{55,  0, 1, 2, 0},
            '{56,  0, 2, 2, 1},
            '{63,  1, 2, 2, 1},
            '{64,  0, 2, 1, 2},
            '{65,  1, 2, 2, 0},
            '{119, 1, 2, 2, 0},
            '{120, 1, 3, 2, 1},
            '{128, 1, 3, 1, 2},
            '{192, 1, 4, 1, 2},
            '{200, 1, 4, 2, 0}
        };

        reset_n      = 1'b0;
        bus.in_valid = 1'b0;
        bus.in_data  = 8'h00;
        bus.in_last  = 1'b0;
        rdy_mode     = 0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_block_valid", 512'(bus.block_valid), 512'(0));
        chk("rst_block_data", bus.block_data, '0);
        reset_n = 1'b1;
        step();
        chk("rst_in_ready", 512'(bus.in_ready), 512'(1));
        chk("rst_block_last", 512'(bus.block_last), 512'(0));
        chk("rst_busy", 512'(bus.busy), 512'(0));

        // "abc": single final block two cycles after the last byte
        run_abc("abc");
        if (got_q.size() > 0) begin
            chk("abc_head", 512'(got_q[0].data[511:480]), 512'(32'h61626380));
            chk("abc_len", 512'(got_q[0].data[63:0]), 512'(64'h18));
            chk("abc_mid", 512'(got_q[0].data[479:64]), '0);
            chk("abc_latency", 512'(got_q[0].cyc - last_acc_cyc), 512'(2));
            abc_ref = got_q[0].data;
        end else begin
            abc_ref = '0;
        end
        chk("abc_busy_after", 512'(bus.busy), 512'(0));

        for (int unsigned v = 0; v < 11; v++) begin
            rdy_mode = 0;
            make_msg(vecs[v].len, vecs[v].pat);
            build_expected();
            got_q.delete();
            send_msg(1'b1);
            compare_blocks($sformatf("len%0d", vecs[v].len));
            chk($sformatf("len%0d_nblk", vecs[v].len), 512'(got_q.size()), 512'(vecs[v].exp_blocks));
            first = got_q.size();
            for (int unsigned i = 0; i < got_q.size(); i++)
                if (first == got_q.size() && got_q[i].cyc > last_acc_cyc) first = i;
            if (first < got_q.size())
                chk($sformatf("len%0d_latency", vecs[v].len),
                    512'(got_q[first].cyc - last_acc_cyc), 512'(vecs[v].exp_lat));
            if (vecs[v].exp_gap != 0 && got_q.size() >= 2)
                chk($sformatf("len%0d_gap", vecs[v].len),
                    512'(got_q[got_q.size() - 1].cyc - got_q[got_q.size() - 2].cyc),
                    512'(vecs[v].exp_gap));
        end

        // Back-pressure: block held stable while block_ready is low
        rdy_mode = 2;
        step();
        run_abc_stall: begin
            msg.delete();
            msg.push_back(8'h61);
            msg.push_back(8'h62);
            msg.push_back(8'h63);
            build_expected();
            got_q.delete();
            send_msg(1'b1);
            w = 0;
            while (!bus.block_valid && w < 50) begin
                step();
                w++;
            end
            chk("stall_valid_seen", 512'(bus.block_valid), 512'(1));
            held = bus.block_data;
            for (int unsigned i = 0; i < 10; i++) begin
                step();
                chk($sformatf("stall_valid%0d", i), 512'(bus.block_valid), 512'(1));
                chk($sformatf("stall_data%0d", i), bus.block_data, held);
                chk($sformatf("stall_in_ready%0d", i), 512'(bus.in_ready), 512'(0));
            end
            rdy_mode = 0;
            step();
            chk("stall_release_in_ready", 512'(bus.in_ready), 512'(1));
            chk("stall_release_valid", 512'(bus.block_valid), 512'(0));
            compare_blocks("stall");
        end

        // Reset in the middle of a message discards it entirely
        make_msg(20, 1);
        got_q.delete();
        send_msg(1'b0);
        chk("midrst_busy_before", 512'(bus.busy), 512'(1));
        reset_n = 1'b0;
        #1;
        chk("midrst_valid", 512'(bus.block_valid), 512'(0));
        chk("midrst_last", 512'(bus.block_last), 512'(0));
        chk("midrst_data", bus.block_data, '0);
        chk("midrst_busy", 512'(bus.busy), 512'(0));
        step();
        step();
        reset_n = 1'b1;
        step();
        chk("midrst_no_block", 512'(got_q.size()), 512'(0));
        run_abc("postrst");
        if (got_q.size() > 0) chk("postrst_same_as_abc", got_q[0].data, abc_ref);

        // Randomized messages with random back-pressure
        rdy_mode = 1;
        for (int unsigned r = 0; r < 12; r++) begin
            make_msg($urandom_range(1, 200), 1);
            build_expected();
            got_q.delete();
            send_msg(1'b1);
            compare_blocks($sformatf("rnd%0d_len%0d", r, msg.size()));
            chk($sformatf("rnd%0d_in_ready", r), 512'(bus.in_ready), 512'(1));
        end
        rdy_mode = 0;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
